// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned BYTES_PER_WORD    = 4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Big-endian byte-to-word shift register with a byte counter.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      word     <= {word[23:0], byte_data};
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  // Fires on the edge that accepts the last byte; byte_cnt wraps to 0 there.
  assign word_full = accept && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream and holds the CPU in reset while loading.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_CNT = 5'(DEPTH);

  state_t           state;
  logic [IDX_W-1:0] word_idx;
  logic [4:0]       limit;
  logic [4:0]       idx_next;
  logic [31:0]      word;
  logic             word_full;
  logic             accept;
  logic             start_ok;
  logic             last_word;

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign idx_next  = 5'(word_idx) + 5'd1;
  assign last_word = ((limit != '0) && (idx_next == limit)) ||
                     (word == HALT_WORD) ||
                     (idx_next == DEPTH_CNT);

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .accept    (accept),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_idx <= '0;
      limit    <= '0;
      err      <= 1'b0;
      cpu_rst  <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state    <= RECV;
            word_idx <= '0;
            limit    <= (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
            err      <= (word_count > DEPTH_CNT);
            cpu_rst  <= 1'b1;
          end
        end
        RECV: begin
          if (word_full) state <= WRITE;
        end
        WRITE: begin
          // The index is left at its final value on termination so it never wraps.
          if (last_word) begin
            state   <= DONE;
            cpu_rst <= 1'b0;
          end else begin
            state    <= RECV;
            word_idx <= word_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign byte_ready = (state == RECV);
  assign im_we      = (state == WRITE);
  assign im_addr    = ADDR_W'({word_idx, 2'b00});
  assign im_wdata   = word;
  assign busy       = (state == RECV) || (state == WRITE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: reference model predicts writes, monitor checks them.
module tb_imem_loader;

  localparam int          DEPTH = 16;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        im_we;
  logic [5:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.ADDR_W(6), .DEPTH(16), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  wr_cyc[$];
  int  start_cyc;
  int  done_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops one expected write.
  always @(negedge clk) begin
    wr_t e;
    if (im_we === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL write_unexpected: got addr %0h data %0h, required no write", im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(im_addr), 64'(e.addr));
        check("write_data", 64'(im_wdata), 64'(e.data));
      end
    end
  end

  // Reference model: writes proceed in order until count limit, halt word or capacity.
  task automatic model(input int wc, input logic [31:0] words[$], output int n);
    int lim;
    lim = (wc > DEPTH) ? DEPTH : wc;
    n = 0;
    for (int i = 0; i < words.size(); i++) begin
      exp_q.push_back(wr_t'{addr: 6'(4 * i), data: words[i]});
      n++;
      if ((lim != 0 && n == lim) || words[i] == HALT || n == DEPTH) break;
    end
  endtask

  task automatic do_start(input int wc);
    word_count = 5'(wc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    check("start_cpu_rst", 64'(cpu_rst), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clear", 64'(done), 64'd0);
    check("start_err", 64'(err), (wc > DEPTH) ? 64'd1 : 64'd0);
  endtask

  task automatic stream(input logic [31:0] words[$], input int stall_after, input int stall_len,
                        input bit rnd, output int nacc);
    logic [7:0]  bq[$];
    logic [31:0] w;
    logic        took;
    int          i;
    int          guard;
    i = 0;
    guard = 0;
    nacc = 0;
    foreach (words[k]) begin
      w = words[k];
      for (int b = 3; b >= 0; b--) bq.push_back(8'(w >> (8 * b)));
    end
    while (i < bq.size() && !done && guard < 4000) begin
      guard++;
      if (rnd && $urandom_range(0, 3) == 0) begin
        byte_valid = 1'b0;
        start = byte_ready && ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data = bq[i];
        @(negedge clk);
        took = byte_ready;
        @(posedge clk); #1;
        if (took) begin
          i++;
          nacc++;
          if (i == stall_after) begin
            byte_valid = 1'b0;
            repeat (stall_len) @(posedge clk);
            #1;
          end
        end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input int wc, input logic [31:0] words[$], input int stall_after,
                          input int stall_len, input bit rnd);
    int nexp;
    int nacc;
    int k;
    wr_cyc.delete();
    model(wc, words, nexp);
    do_start(wc);
    stream(words, stall_after, stall_len, rnd, nacc);
    k = 0;
    done_cyc = -1;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (done) done_cyc = cyc;
    check("end_done", 64'(done), 64'd1);
    check("end_cpu_rst", 64'(cpu_rst), 64'd0);
    check("end_byte_ready", 64'(byte_ready), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("end_err", 64'(err), (wc > DEPTH) ? 64'd1 : 64'd0);
    check("end_pending_writes", 64'(exp_q.size()), 64'd0);
    check("bytes_consumed", 64'(nacc), 64'(4 * nexp));
    check("write_count", 64'(wr_cyc.size()), 64'(nexp));
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] r;
    int          wc;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_im_we", 64'(im_we), 64'd0);
    check("rst_im_addr", 64'(im_addr), 64'd0);
    check("rst_im_wdata", 64'(im_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_cpu_rst", 64'(cpu_rst), 64'd1);
    check("idle_byte_ready", 64'(byte_ready), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Counted load, back-to-back bytes; cycle numbers count the start cycle as 0.
    w.delete();
    w.push_back(32'h2008_0005);
    w.push_back(32'h0000_0000);
    run_load(2, w, -1, 0, 1'b0);
    if (wr_cyc.size() >= 2) begin
      check("counted_we1_cycle", 64'(wr_cyc[0] - (start_cyc - 1)), 64'd5);
      check("counted_we2_cycle", 64'(wr_cyc[1] - (start_cyc - 1)), 64'd10);
    end
    check("counted_done_cycle", 64'(done_cyc - (start_cyc - 1)), 64'd11);

    // Same stream with a 3-cycle valid gap after byte 2.
    run_load(2, w, 2, 3, 1'b0);
    if (wr_cyc.size() >= 2) begin
      check("stall_we1_cycle", 64'(wr_cyc[0] - (start_cyc - 1)), 64'd8);
      check("stall_we2_cycle", 64'(wr_cyc[1] - (start_cyc - 1)), 64'd13);
    end

    // Halt word ends an unbounded load; third word must never be taken.
    w.delete();
    w.push_back(32'h0000_0001);
    w.push_back(HALT);
    w.push_back(32'h1234_5678);
    run_load(0, w, -1, 0, 1'b0);

    // Overflow: count clamped to capacity.
    w.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      r = $urandom;
      if (r == HALT) r = 32'h0;
      w.push_back(r);
    end
    run_load(20, w, -1, 0, 1'b0);

    // Reset mid-load after two bytes.
    do_start(3);
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    @(posedge clk); #1;
    byte_data = 8'hBB;
    @(posedge clk); #1;
    rst = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_byte_ready", 64'(byte_ready), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_idle_busy", 64'(busy), 64'd0);
    w.delete();
    w.push_back(32'hCAFE_F00D);
    w.push_back(32'h0000_0013);
    run_load(2, w, -1, 0, 1'b0);

    // Randomized loads with random stalls and ignored start pulses.
    for (int t = 0; t < 8; t++) begin
      wc = $urandom_range(0, 20);
      w.delete();
      for (int i = 0; i < DEPTH + 2; i++) begin
        r = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
        w.push_back(r);
      end
      run_load(wc, w, -1, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
